// File: rtl/det_ch_scheduler_pkg.sv
// det_pkg: state encoding shared by the 1101 detection engine and the scheduler.
package det_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

endpackage

// File: rtl/det_ch_scheduler_nsl.sv
// det_1101_nsl: combinational next-state and hit decode of the
// non-overlapping 1101 Mealy detector.
module det_1101_nsl
  import det_pkg::*;
(
  input  det_state_t state,
  input  logic       din,
  output det_state_t next_state,
  output logic       hit
);

  // Transition table; a completed match restarts from S0.
  always_comb begin
    next_state = S0;
    hit        = 1'b0;
    case (state)
      S0: begin
        if (din) next_state = S1;
        else     next_state = S0;
      end
      S1: begin
        if (din) next_state = S2;
        else     next_state = S0;
      end
      S2: begin
        if (din) next_state = S2;
        else     next_state = S3;
      end
      S3: begin
        next_state = S0;
        if (din) hit = 1'b1;
        else     hit = 1'b0;
      end
      default: begin
        next_state = S0;
        hit        = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/det_ch_scheduler.sv
// det_ch_scheduler: round-robin sharing of one 1101 detector across NUM_CH bit streams.
// Define DET_HIT_CNT_EN to add per-channel saturating hit counters.
module det_ch_scheduler
  import det_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] bit_valid,
  input  logic [NUM_CH-1:0] bit_din,
  output logic [NUM_CH-1:0] bit_ready,
  input  logic [NUM_CH-1:0] ch_clr,
  output logic              hit_valid,
  output logic [CH_W-1:0]   hit_ch,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_rd
);

  det_state_t      ctx_r [NUM_CH];
  logic [CH_W-1:0] rr_ptr_r;
  logic [CH_W-1:0] gnt_idx_s;
  logic            gnt_any_s;
  det_state_t      cur_state_s;
  det_state_t      nxt_state_s;
  logic            gnt_din_s;
  logic            eng_hit_s;
  logic            hit_now_s;

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    bit_ready = {NUM_CH{1'b0}};
    gnt_idx_s = {CH_W{1'b0}};
    gnt_any_s = 1'b0;
    if (en) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        if (!gnt_any_s && bit_valid[(int'(rr_ptr_r) + i) % NUM_CH]) begin
          gnt_any_s = 1'b1;
          gnt_idx_s = CH_W'((int'(rr_ptr_r) + i) % NUM_CH);
          bit_ready[(int'(rr_ptr_r) + i) % NUM_CH] = 1'b1;
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
    end else begin
      bit_ready = {NUM_CH{1'b0}};
    end
  end

  assign cur_state_s = ctx_r[gnt_idx_s];
  assign gnt_din_s   = bit_din[gnt_idx_s];

  det_1101_nsl u_engine (
    .state      (cur_state_s),
    .din        (gnt_din_s),
    .next_state (nxt_state_s),
    .hit        (eng_hit_s)
  );

  // A clear on the granted channel swallows the bit and suppresses its hit.
  assign hit_now_s = gnt_any_s & eng_hit_s & ~ch_clr[gnt_idx_s];

  // Per-channel context storage; only the granted channel advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) ctx_r[k] <= S0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_clr[k])                                  ctx_r[k] <= S0;
        else if (gnt_any_s && (gnt_idx_s == CH_W'(k)))  ctx_r[k] <= nxt_state_s;
        else                                            ctx_r[k] <= ctx_r[k];
      end
    end
  end

  // Round-robin pointer and registered hit output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= CH_W'(NUM_CH - 1);
      hit_valid <= 1'b0;
      hit_ch    <= {CH_W{1'b0}};
    end else begin
      if (gnt_any_s) rr_ptr_r <= gnt_idx_s;
      else           rr_ptr_r <= rr_ptr_r;
      hit_valid <= hit_now_s;
      if (hit_now_s) hit_ch <= gnt_idx_s;
      else           hit_ch <= hit_ch;
    end
  end

`ifdef DET_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_r [NUM_CH];

  // Saturating per-channel hit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) cnt_r[k] <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_clr[k])
          cnt_r[k] <= {CNT_W{1'b0}};
        else if (hit_now_s && (gnt_idx_s == CH_W'(k)) && (cnt_r[k] != {CNT_W{1'b1}}))
          cnt_r[k] <= cnt_r[k] + CNT_W'(1);
        else
          cnt_r[k] <= cnt_r[k];
      end
    end
  end

  assign cnt_rd = (int'(cnt_sel) < NUM_CH) ? cnt_r[cnt_sel] : {CNT_W{1'b0}};
`else
  logic unused_s;
  assign unused_s = ^cnt_sel;
  assign cnt_rd   = {CNT_W{1'b0}};
`endif

endmodule
